// File: rtl/wisc_pkg.sv
// Shared WISC-SP13 encodings: ALU function codes, major opcodes, set-condition codes and
// the decoded control bundle passed from the decoder to the issue register.
package wisc_pkg;

  localparam logic [3:0] AluRol  = 4'b0000;
  localparam logic [3:0] AluSll  = 4'b0001;
  localparam logic [3:0] AluRor  = 4'b0010;
  localparam logic [3:0] AluSrl  = 4'b0011;
  localparam logic [3:0] AluAdd  = 4'b0100;
  localparam logic [3:0] AluOr   = 4'b0101;
  localparam logic [3:0] AluXor  = 4'b0110;
  localparam logic [3:0] AluAndn = 4'b0111;
  localparam logic [3:0] AluBtr  = 4'b1000;
  localparam logic [3:0] AluSlbi = 4'b1001;
  localparam logic [3:0] AluLbi  = 4'b1011;

  localparam logic [4:0] OpAddi  = 5'b01000;
  localparam logic [4:0] OpSubi  = 5'b01001;
  localparam logic [4:0] OpXori  = 5'b01010;
  localparam logic [4:0] OpAndni = 5'b01011;
  localparam logic [4:0] OpRoli  = 5'b10100;
  localparam logic [4:0] OpSlli  = 5'b10101;
  localparam logic [4:0] OpRori  = 5'b10110;
  localparam logic [4:0] OpSrli  = 5'b10111;
  localparam logic [4:0] OpSlbi  = 5'b10010;
  localparam logic [4:0] OpLbi   = 5'b11000;
  localparam logic [4:0] OpBtr   = 5'b11001;
  localparam logic [4:0] OpShft  = 5'b11010;
  localparam logic [4:0] OpArith = 5'b11011;
  localparam logic [4:0] OpSeq   = 5'b11100;
  localparam logic [4:0] OpSlt   = 5'b11101;
  localparam logic [4:0] OpSle   = 5'b11110;
  localparam logic [4:0] OpSco   = 5'b11111;

  localparam logic [2:0] SetNone = 3'b000;
  localparam logic [2:0] SetSeq  = 3'b100;
  localparam logic [2:0] SetSlt  = 3'b101;
  localparam logic [2:0] SetSle  = 3'b110;
  localparam logic [2:0] SetSco  = 3'b111;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        inv_a;
    logic        cin;
    logic        use_imm;
    logic [15:0] imm;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic        wr_en;
    logic        is_alu;
    logic [2:0]  set_cond;
  } ctrl_t;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] zext5(input logic [4:0] v);
    return {11'b0, v};
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] zext8(input logic [7:0] v);
    return {8'b0, v};
  endfunction

  // Rotate/shift codes line up with the two low bits of both the opcode and func field.
  function automatic logic [3:0] shift_op(input logic [1:0] sel);
    return {2'b00, sel};
  endfunction

endpackage

// File: rtl/alu_dec.sv
// Pure combinational decode of a WISC-SP13 instruction word into ALU issue controls.
module alu_dec
  import wisc_pkg::*;
(
  input  logic [15:0] i_instr,
  output ctrl_t       o_ctrl
);

  logic [4:0] w_op;
  logic [1:0] w_func;

  assign w_op   = i_instr[15:11];
  assign w_func = i_instr[1:0];

  always_comb begin
    o_ctrl          = '0;
    o_ctrl.alu_op   = AluAdd;
    o_ctrl.set_cond = SetNone;
    case (w_op)
      OpAddi, OpSubi, OpXori, OpAndni, OpRoli, OpSlli, OpRori, OpSrli: begin
        o_ctrl.is_alu  = 1'b1;
        o_ctrl.wr_en   = 1'b1;
        o_ctrl.use_imm = 1'b1;
        o_ctrl.rs      = i_instr[10:8];
        o_ctrl.rd      = i_instr[7:5];
        o_ctrl.imm     = zext5(i_instr[4:0]);
        case (w_op)
          OpAddi: o_ctrl.imm = sext5(i_instr[4:0]);
          // SUBI computes imm - Rs as ~Rs + imm + 1.
          OpSubi: begin
            o_ctrl.imm   = sext5(i_instr[4:0]);
            o_ctrl.inv_a = 1'b1;
            o_ctrl.cin   = 1'b1;
          end
          OpXori:  o_ctrl.alu_op = AluXor;
          OpAndni: o_ctrl.alu_op = AluAndn;
          default: o_ctrl.alu_op = shift_op(w_op[1:0]);
        endcase
      end
      OpArith, OpShft, OpSeq, OpSlt, OpSle, OpSco: begin
        o_ctrl.is_alu = 1'b1;
        o_ctrl.wr_en  = 1'b1;
        o_ctrl.rs     = i_instr[10:8];
        o_ctrl.rt     = i_instr[7:5];
        o_ctrl.rd     = i_instr[4:2];
        case (w_op)
          OpArith: begin
            case (w_func)
              2'b00: o_ctrl.alu_op = AluAdd;
              2'b01: begin
                o_ctrl.inv_a = 1'b1;
                o_ctrl.cin   = 1'b1;
              end
              2'b10: o_ctrl.alu_op = AluXor;
              default: o_ctrl.alu_op = AluAndn;
            endcase
          end
          OpShft: o_ctrl.alu_op = shift_op(w_func);
          default: begin
            // Compares subtract (Rt - Rs); SCO needs the plain carry-out of Rs + Rt.
            o_ctrl.set_cond = {1'b1, w_op[1:0]};
            o_ctrl.inv_a    = (w_op != OpSco);
            o_ctrl.cin      = (w_op != OpSco);
          end
        endcase
      end
      OpBtr: begin
        o_ctrl.is_alu = 1'b1;
        o_ctrl.wr_en  = 1'b1;
        o_ctrl.alu_op = AluBtr;
        o_ctrl.rs     = i_instr[10:8];
        o_ctrl.rd     = i_instr[4:2];
      end
      OpLbi, OpSlbi: begin
        o_ctrl.is_alu  = 1'b1;
        o_ctrl.wr_en   = 1'b1;
        o_ctrl.use_imm = 1'b1;
        o_ctrl.rs      = i_instr[10:8];
        o_ctrl.rd      = i_instr[10:8];
        if (w_op == OpLbi) begin
          o_ctrl.alu_op = AluLbi;
          o_ctrl.imm    = sext8(i_instr[7:0]);
        end else begin
          o_ctrl.alu_op = AluSlbi;
          o_ctrl.imm    = zext8(i_instr[7:0]);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// Single-entry issue register: captures decoded ALU controls with a valid/ready handshake
// and flush; the held entry stays stable while the consumer stalls.
module alu_issue
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic        inv_a,
  output logic        cin,
  output logic        use_imm,
  output logic [15:0] imm,
  output logic [2:0]  rs,
  output logic [2:0]  rt,
  output logic [2:0]  rd,
  output logic        wr_en,
  output logic        is_alu,
  output logic [2:0]  set_cond
);

  ctrl_t w_dec;
  ctrl_t r_ctrl;
  logic  r_valid;
  logic  w_accept;

  alu_dec u_alu_dec (
    .i_instr (instr),
    .o_ctrl  (w_dec)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_ctrl <= w_dec;
      end
    end
  end

  assign out_valid = r_valid;
  assign alu_op    = r_ctrl.alu_op;
  assign inv_a     = r_ctrl.inv_a;
  assign cin       = r_ctrl.cin;
  assign use_imm   = r_ctrl.use_imm;
  assign imm       = r_ctrl.imm;
  assign rs        = r_ctrl.rs;
  assign rt        = r_ctrl.rt;
  assign rd        = r_ctrl.rd;
  assign wr_en     = r_ctrl.wr_en;
  assign is_alu    = r_ctrl.is_alu;
  assign set_cond  = r_ctrl.set_cond;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, stall/hold, flush and mid-stall reset.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic        inv_a;
  logic        cin;
  logic        use_imm;
  logic [15:0] imm;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [2:0]  rd;
  logic        wr_en;
  logic        is_alu;
  logic [2:0]  set_cond;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .instr     (instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .inv_a     (inv_a),
    .cin       (cin),
    .use_imm   (use_imm),
    .imm       (imm),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .wr_en     (wr_en),
    .is_alu    (is_alu),
    .set_cond  (set_cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [3:0]  op;
    logic        inv;
    logic        ci;
    logic        uimm;
    logic [15:0] imm;
    logic [2:0]  rd;
    logic [2:0]  sc;
    logic        wr;
    logic        alu;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                 instr     op    inv   cin   uimm  imm        rd    sc      wr    alu
    vecs[0]  = '{16'h4B82, 4'h4, 1'b1, 1'b1, 1'b1, 16'h0002, 3'd4, 3'b000, 1'b1, 1'b1}; // SUBI
    vecs[1]  = '{16'h5030, 4'h6, 1'b0, 1'b0, 1'b1, 16'h0010, 3'd1, 3'b000, 1'b1, 1'b1}; // XORI
    vecs[2]  = '{16'h593F, 4'h7, 1'b0, 1'b0, 1'b1, 16'h001F, 3'd1, 3'b000, 1'b1, 1'b1}; // ANDNI
    vecs[3]  = '{16'hBA65, 4'h3, 1'b0, 1'b0, 1'b1, 16'h0005, 3'd3, 3'b000, 1'b1, 1'b1}; // SRLI
    vecs[4]  = '{16'hA001, 4'h0, 1'b0, 1'b0, 1'b1, 16'h0001, 3'd0, 3'b000, 1'b1, 1'b1}; // ROLI
    vecs[5]  = '{16'hDCBA, 4'h6, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd6, 3'b000, 1'b1, 1'b1}; // XOR
    vecs[6]  = '{16'hD126, 4'h2, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd1, 3'b000, 1'b1, 1'b1}; // ROR
    vecs[7]  = '{16'hCA1C, 4'h8, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd7, 3'b000, 1'b1, 1'b1}; // BTR
    vecs[8]  = '{16'h95F0, 4'h9, 1'b0, 1'b0, 1'b1, 16'h00F0, 3'd5, 3'b000, 1'b1, 1'b1}; // SLBI
    vecs[9]  = '{16'hE94C, 4'h4, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd3, 3'b101, 1'b1, 1'b1}; // SLT
    vecs[10] = '{16'hF94C, 4'h4, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd3, 3'b111, 1'b1, 1'b1}; // SCO
    vecs[11] = '{16'h0800, 4'h4, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 3'b000, 1'b0, 1'b0}; // NOP

    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = 16'h0000;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_imm", 32'(imm), 32'd0);
    #3 rst = 1'b0;
    step();

    // ADDI R2,R1,-1
    in_valid = 1'b1;
    instr    = 16'h415F;
    #1 check("addi_in_ready", 32'(in_ready), 32'd1);
    step();
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_alu_op", 32'(alu_op), 32'h4);
    check("addi_inv_cin", 32'({inv_a, cin}), 32'd0);
    check("addi_use_imm", 32'(use_imm), 32'd1);
    check("addi_imm", 32'(imm), 32'hFFFF);
    check("addi_rs", 32'(rs), 32'd1);
    check("addi_rd", 32'(rd), 32'd2);
    check("addi_wr_en", 32'(wr_en), 32'd1);

    // SUB R3 = R2 - R1
    instr = 16'hD94D;
    step();
    check("sub_alu_op", 32'(alu_op), 32'h4);
    check("sub_inv_cin", 32'({inv_a, cin}), 32'd3);
    check("sub_use_imm", 32'(use_imm), 32'd0);
    check("sub_regs", 32'({rs, rt, rd}), 32'({3'd1, 3'd2, 3'd3}));

    // LBI R4,0x80
    instr = 16'hC480;
    step();
    check("lbi_alu_op", 32'(alu_op), 32'hB);
    check("lbi_imm", 32'(imm), 32'hFF80);
    check("lbi_rd", 32'(rd), 32'd4);
    check("lbi_wr_en", 32'(wr_en), 32'd1);

    for (int i = 0; i < 12; i++) begin
      instr = vecs[i].instr;
      step();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].op));
      check($sformatf("v%0d_inv_a", i), 32'(inv_a), 32'(vecs[i].inv));
      check($sformatf("v%0d_cin", i), 32'(cin), 32'(vecs[i].ci));
      check($sformatf("v%0d_use_imm", i), 32'(use_imm), 32'(vecs[i].uimm));
      check($sformatf("v%0d_imm", i), 32'(imm), 32'(vecs[i].imm));
      check($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
      check($sformatf("v%0d_set_cond", i), 32'(set_cond), 32'(vecs[i].sc));
      check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].wr));
      check($sformatf("v%0d_is_alu", i), 32'(is_alu), 32'(vecs[i].alu));
    end

    // Drain with no new input
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Back-to-back with consumer stalled for two cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 16'h415F;
    step();
    check("stall_a_valid", 32'(out_valid), 32'd1);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    instr = 16'hD94D;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_imm", c), 32'(imm), 32'hFFFF);
      check($sformatf("hold%0d_rd", c), 32'(rd), 32'd2);
      check($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);
    step();
    check("b_valid", 32'(out_valid), 32'd1);
    check("b_rd", 32'(rd), 32'd3);
    check("b_inv_a", 32'(inv_a), 32'd1);
    in_valid = 1'b0;
    step();
    check("b_drain_valid", 32'(out_valid), 32'd0);

    // Flush with a held entry and a new instruction offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 16'h415F;
    step();
    check("fl_held_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    instr = 16'hC480;
    step();
    check("fl_valid", 32'(out_valid), 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check("fl_after_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a stall
    in_valid = 1'b1;
    instr    = 16'h415F;
    step();
    check("rs_held_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_in_ready", 32'(in_ready), 32'd1);
    check("rs_alu_op", 32'(alu_op), 32'd0);
    check("rs_imm", 32'(imm), 32'd0);
    check("rs_ctrl", 32'({wr_en, is_alu, use_imm, rd, rs}), 32'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = 16'hD94D;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_rd", 32'(rd), 32'd3);
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk, in, 1, sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst, in, 1, asynchronous active-high reset.
REQ-003 SHALL have ports: in_valid, in, 1, instruction word present.
REQ-004 SHALL have ports: instr, in, 16, WISC-SP13 instruction word.
REQ-005 SHALL have ports: in_ready, out, 1, stage can accept.
REQ-006 SHALL have ports: flush, in, 1, discard held and incoming instruction.
REQ-007 SHALL have ports: out_valid, out, 1, registered controls valid.
REQ-008 SHALL have ports: out_ready, in, 1, consumer accepts.
REQ-009 SHALL have ports: alu_op, out, 4, ALU function code.
REQ-010 SHALL have ports: inv_a, out, 1, invert operand A.
REQ-011 SHALL have ports: cin, out, 1, adder carry-in.
REQ-012 SHALL have ports: use_imm, out, 1, B operand from imm, else Rt.
REQ-013 SHALL have ports: imm, out, 16, extended immediate.
REQ-014 SHALL have ports: rs, rt, rd, out, 3 each, register indices; A operand always Rs.
REQ-015 SHALL have ports: wr_en, out, 1, writes rd.
REQ-016 SHALL have ports: is_alu, out, 1, instruction uses ALU.
REQ-017 SHALL have ports: set_cond, out, 3, 000 none, 100 SEQ, 101 SLT, 110 SLE, 111 SCO.

Function
REQ-018 SHALL register decoded controls; latency exactly 1 cycle from accepted input (in_valid & in_ready) to out_valid.
REQ-019 SHALL drive in_ready = !out_valid | out_ready (single-entry pipeline register, no combinational path from in_valid).
REQ-020 SHALL hold all outputs stable while out_valid & !out_ready.
REQ-021 SHALL clear out_valid when out_ready and no accept occurs in that cycle; accept and drain in the same cycle replaces the entry.
REQ-022 SHALL, with flush high, clear out_valid next cycle and not capture instr, regardless of in_valid/out_ready.
REQ-023 SHALL use ALU codes: 0000 ROL, 0001 SLL, 0010 ROR, 0011 SRL, 0100 ADD, 0101 OR, 0110 XOR, 0111 ANDN, 1000 BTR, 1001 SLBI, 1011 LBI.
REQ-024 SHALL decode opcode instr[15:11]: 01000 ADDI, 01001 SUBI, 01010 XORI, 01011 ANDNI, 10100 ROLI, 10101 SLLI, 10110 RORI, 10111 SRLI; fields rs=[10:8], rd=[7:5], imm5=[4:0].
REQ-025 SHALL sign-extend imm5 for ADDI/SUBI and zero-extend for XORI/ANDNI/shift immediates.
REQ-026 SHALL decode 11011 (ADD/SUB/XOR/ANDN by func [1:0]=00/01/10/11) and 11010 (ROL/SLL/ROR/SRL by func); rs=[10:8], rt=[7:5], rd=[4:2], use_imm=0.
REQ-027 SHALL implement SUB and SUBI as B-A: alu_op 0100, inv_a=1, cin=1; all other ops inv_a=0, cin=0.
REQ-028 SHALL decode 11001 BTR (rd=[4:2]), 11000 LBI (rd=[10:8], imm8 sign-extended), 10010 SLBI (rd=[10:8], imm8 zero-extended, rs=[10:8]).
REQ-029 SHALL decode 11100-11111 SEQ/SLT/SLE/SCO as R-format: SEQ/SLT/SLE alu_op 0100 inv_a=1 cin=1; SCO alu_op 0100 inv_a=0 cin=0; set_cond per REQ-017.
REQ-030 SHALL output is_alu=0, wr_en=0, alu_op=0100, set_cond=000 for any other opcode.

Reset
REQ-031 SHALL, while rst high, force out_valid=0, all control outputs 0, in_ready=1, asynchronously.
REQ-032 SHALL discard any held entry on reset mid-operation; first accept allowed on first rising edge after rst deasserts.

Structure
REQ-033 SHALL place ALU codes, 5-bit opcodes and set_cond codes in shared package wisc_pkg.
REQ-034 SHALL split pure combinational decode into sub-module alu_dec; alu_issue holds the register and handshake.

Verification
REQ-035 SHALL test instr 0x415F (ADDI R2,R1,-1) -> next cycle alu_op 0100, inv_a 0, cin 0, use_imm 1, imm 0xFFFF, rs 1, rd 2, wr_en 1.
REQ-036 SHALL test 0xD94D (SUB R3=R2-R1) -> alu_op 0100, inv_a 1, cin 1, use_imm 0, rs 1, rt 2, rd 3.
REQ-037 SHALL test 0xC480 (LBI R4,0x80) -> alu_op 1011, imm 0xFF80, rd 4, wr_en 1.
REQ-038 SHALL test two back-to-back instrs with out_ready low 2 cycles -> first held stable, in_ready 0, second appears on cycle after drain.
REQ-039 SHALL test flush with valid held entry and in_valid high -> out_valid 0 next cycle, neither instruction emitted.
REQ-040 SHALL test rst asserted mid-stall -> out_valid 0 immediately, in_ready 1, outputs 0.
